// File: rtl/prefix_adder_pkg.sv
// prefix_adder_pkg: shared types and tree-shape helpers for prefix_adder_pipe.
// The (G,P) pair type, the black-cell operator, and the functions that size the
// prefix tree (number of levels and the level after which the optional
// mid-tree register sits).
package prefix_adder_pkg;

  localparam int DEFAULT_WIDTH = 32;

  typedef struct packed {
    logic g;
    logic p;
  } pg_t;

  // Number of prefix levels for a power-of-two operand width.
  function automatic int levels_f(input int width);
    return $clog2(width);
  endfunction

  // Level boundary where the optional mid-tree register is inserted.
  function automatic int mid_level_f(input int width);
    return levels_f(width) / 2;
  endfunction

  // Black cell: (G,P)hi o (G,P)lo.
  function automatic pg_t pg_combine(input pg_t hi, input pg_t lo);
    pg_t res;
    res.g = hi.g | (hi.p & lo.g);
    res.p = hi.p & lo.p;
    return res;
  endfunction

endpackage

// File: rtl/prefix_adder_pipe_prefix_cell.sv
// prefix_cell: combinational black cell of the parallel-prefix tree.
// Combines the higher-order group (hi) with the adjacent lower group (lo).
module prefix_cell
  import prefix_adder_pkg::*;
(
  input  logic i_g_hi,
  input  logic i_p_hi,
  input  logic i_g_lo,
  input  logic i_p_lo,
  output logic o_g,
  output logic o_p
);

  pg_t w_hi;
  pg_t w_lo;
  pg_t w_res;

  // Pack the operands and apply the prefix operator.
  always_comb begin
    w_hi.g = i_g_hi;
    w_hi.p = i_p_hi;
    w_lo.g = i_g_lo;
    w_lo.p = i_p_lo;
    w_res  = pg_combine(w_hi, w_lo);
  end

  assign o_g = w_res.g;
  assign o_p = w_res.p;

endmodule

// File: rtl/prefix_adder_pipe.sv
// prefix_adder_pipe: pipelined Kogge-Stone parallel-prefix adder/subtractor
// with valid/ready handshake and signed-overflow flag.
//   S1 : bitwise PG with carry-in folded into bit 0 (registered)
//   S2 : log2(WIDTH)-level prefix tree, carries, sum XOR (registered)
// Optional build macro PREFIX_ADDER_MID_REG_EN adds a register (S2a) in the
// middle of the prefix tree; latency goes from 2 to 3, results are identical.
module prefix_adder_pipe
  import prefix_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
)(
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int L_LEVELS = levels_f(WIDTH);
  localparam int L_MID    = mid_level_f(WIDTH);

  // ---------------------------------------------------------------- S1
  logic [WIDTH-1:0] w_bb;
  logic [WIDTH-1:0] w_p0;
  logic [WIDTH-1:0] w_g0;
  logic             w_c0;

  logic             r_v1;
  logic [WIDTH-1:0] r_p1;
  logic [WIDTH-1:0] r_g1;
  logic             r_c01;

  logic             w_rdy1;
  logic             w_rdy2;

  // Bitwise propagate/generate; the carry-in becomes part of bit-0 generate
  // so the tree needs no separate carry-in input.
  always_comb begin
    w_bb    = b ^ {WIDTH{sub}};
    w_c0    = sub | cin;
    w_p0    = a ^ w_bb;
    w_g0    = a & w_bb;
    w_g0[0] = w_g0[0] | (w_p0[0] & w_c0);
  end

  // S1 register: load a new beat whenever the stage can hand its content on.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_v1  <= 1'b0;
      r_p1  <= '0;
      r_g1  <= '0;
      r_c01 <= 1'b0;
    end else if (w_rdy1) begin
      r_v1 <= in_valid;
      if (in_valid) begin
        r_p1  <= w_p0;
        r_g1  <= w_g0;
        r_c01 <= w_c0;
      end
    end
  end

  // ---------------------------------------------------------- prefix tree
  // Signals presented to the levels at and above L_MID: either straight from
  // the lower half of the tree or from the mid register.
  logic [WIDTH-1:0] w_g_tap;
  logic [WIDTH-1:0] w_p_tap;
  logic [WIDTH-1:0] w_g_mid;
  logic [WIDTH-1:0] w_p_mid;
  logic [WIDTH-1:0] w_pbit_s2;
  logic             w_c0_s2;
  logic             w_v_s2;

  for (genvar k = 0; k < L_LEVELS; k++) begin : g_lvl
    localparam int D = 1 << k;
    logic [WIDTH-1:0] w_g_in;
    logic [WIDTH-1:0] w_p_in;
    logic [WIDTH-1:0] w_g_out;
    logic [WIDTH-1:0] w_p_out;

    if (k == L_MID) begin : g_src_mid
      assign w_g_in = w_g_mid;
      assign w_p_in = w_p_mid;
    end else if (k == 0) begin : g_src_s1
      assign w_g_in = r_g1;
      assign w_p_in = r_p1;
    end else begin : g_src_prev
      assign w_g_in = g_lvl[k-1].w_g_out;
      assign w_p_in = g_lvl[k-1].w_p_out;
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      if (i >= D) begin : g_cell
        prefix_cell u_cell (
          .i_g_hi (w_g_in[i]),
          .i_p_hi (w_p_in[i]),
          .i_g_lo (w_g_in[i-D]),
          .i_p_lo (w_p_in[i-D]),
          .o_g    (w_g_out[i]),
          .o_p    (w_p_out[i])
        );
      end else begin : g_pass
        assign w_g_out[i] = w_g_in[i];
        assign w_p_out[i] = w_p_in[i];
      end
    end
  end

  if (L_MID == 0) begin : g_tap_s1
    assign w_g_tap = r_g1;
    assign w_p_tap = r_p1;
  end else begin : g_tap_tree
    assign w_g_tap = g_lvl[L_MID-1].w_g_out;
    assign w_p_tap = g_lvl[L_MID-1].w_p_out;
  end

`ifdef PREFIX_ADDER_MID_REG_EN
  logic             r_vm;
  logic [WIDTH-1:0] r_gm;
  logic [WIDTH-1:0] r_pm;
  logic [WIDTH-1:0] r_pbm;
  logic             r_c0m;
  logic             w_rdym;

  assign w_rdym = !r_vm | w_rdy2;
  assign w_rdy1 = !r_v1 | w_rdym;

  // S2a register: partial group G/P plus the bitwise p and c0 the sum needs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vm  <= 1'b0;
      r_gm  <= '0;
      r_pm  <= '0;
      r_pbm <= '0;
      r_c0m <= 1'b0;
    end else if (w_rdym) begin
      r_vm <= r_v1;
      if (r_v1) begin
        r_gm  <= w_g_tap;
        r_pm  <= w_p_tap;
        r_pbm <= r_p1;
        r_c0m <= r_c01;
      end
    end
  end

  assign w_g_mid   = r_gm;
  assign w_p_mid   = r_pm;
  assign w_pbit_s2 = r_pbm;
  assign w_c0_s2   = r_c0m;
  assign w_v_s2    = r_vm;
`else
  assign w_rdy1    = !r_v1 | w_rdy2;
  assign w_g_mid   = w_g_tap;
  assign w_p_mid   = w_p_tap;
  assign w_pbit_s2 = r_p1;
  assign w_c0_s2   = r_c01;
  assign w_v_s2    = r_v1;
`endif

  // ---------------------------------------------------------------- S2
  logic [WIDTH-1:0] w_gfin;
  logic [WIDTH-1:0] w_carry;
  logic [WIDTH-1:0] w_sum;
  logic             w_unused_pfin;

  assign w_gfin  = g_lvl[L_LEVELS-1].w_g_out;
  assign w_carry = {w_gfin[WIDTH-2:0], w_c0_s2};
  assign w_sum   = w_pbit_s2 ^ w_carry;

  // Group propagate out of the last level has no consumer.
  assign w_unused_pfin = ^g_lvl[L_LEVELS-1].w_p_out;

  logic             r_v2;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_ovf;

  assign w_rdy2 = !r_v2 | out_ready;

  // Result register; held while the consumer stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_v2   <= 1'b0;
      r_sum  <= '0;
      r_cout <= 1'b0;
      r_ovf  <= 1'b0;
    end else if (w_rdy2) begin
      r_v2 <= w_v_s2;
      if (w_v_s2) begin
        r_sum  <= w_sum;
        r_cout <= w_gfin[WIDTH-1];
        r_ovf  <= w_gfin[WIDTH-1] ^ w_gfin[WIDTH-2];
      end
    end
  end

  assign in_ready  = w_rdy1 & !rst;
  assign out_valid = r_v2;
  assign sum       = r_sum;
  assign cout      = r_cout;
  assign ovf       = r_ovf;

endmodule

// File: tb/tb_prefix_adder_pipe.sv
// Self-checking bench for prefix_adder_pipe (WIDTH=32): directed table,
// stall, mid-flight reset and a long random back-to-back stream, all scored
// through an in-order expected-result queue.
module tb_prefix_adder_pipe;

  localparam int W = 32;
`ifdef PREFIX_ADDER_MID_REG_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  prefix_adder_pipe #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } vec_t;

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    int           acc_cyc;
    bit           chk_lat;
  } exp_t;

  exp_t sb[$];
  int   n_assert = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   n_sent   = 0;
  int   n_recv   = 0;
  int   wait_cnt = 0;
  bit   lat_exact = 1'b1;

  bit           held = 1'b0;
  logic [W-1:0] h_sum;
  logic         h_cout;
  logic         h_ovf;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] a_i, input logic [W-1:0] b_i,
                                 input logic cin_i, input logic sub_i);
    exp_t         e;
    logic [W-1:0] bb;
    logic [W:0]   full;
    bb   = sub_i ? ~b_i : b_i;
    full = {1'b0, a_i} + {1'b0, bb} + {{W{1'b0}}, (sub_i ? 1'b1 : cin_i)};
    e.sum     = full[W-1:0];
    e.cout    = full[W];
    e.ovf     = (a_i[W-1] == bb[W-1]) && (full[W-1] != a_i[W-1]);
    e.acc_cyc = 0;
    e.chk_lat = 1'b0;
    return e;
  endfunction

  // Drive one beat, holding it until accepted; expected result queued on accept.
  task automatic send(input logic [W-1:0] a_i, input logic [W-1:0] b_i,
                      input logic cin_i, input logic sub_i, input exp_t e);
    int t = 0;
    bit acc = 1'b0;
    a = a_i; b = b_i; cin = cin_i; sub = sub_i; in_valid = 1'b1;
    while (1) begin
      @(negedge clk);
      if (in_ready) begin
        e.acc_cyc = cyc;
        e.chk_lat = lat_exact;
        sb.push_back(e);
        n_sent++;
        acc = 1'b1;
      end else begin
        wait_cnt++;
      end
      @(posedge clk); #1;
      if (acc) break;
      t++;
      if (t > 200) begin
        n_assert++; n_fail++;
        $display("FAIL accept_timeout: in_ready never rose within %0d cycles", t);
        break;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic send_model(input logic [W-1:0] a_i, input logic [W-1:0] b_i,
                            input logic cin_i, input logic sub_i);
    send(a_i, b_i, cin_i, sub_i, model(a_i, b_i, cin_i, sub_i));
  endtask

  task automatic drain();
    int t = 0;
    while (sb.size() != 0 && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    chk("drain_queue_empty", sb.size(), 0);
  endtask

  // Output monitor: hold-stability and in-order scoreboard compare.
  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
      held = 1'b0;
    end else begin
      if (held) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_sum", sum, h_sum);
        chk("hold_cout_ovf", {cout, ovf}, {h_cout, h_ovf});
      end
      if (out_valid && out_ready) begin
        n_recv++;
        if (sb.size() == 0) begin
          n_assert++; n_fail++;
          $display("FAIL unexpected_beat: got sum 0x%0h, expected no output", sum);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("sum", sum, e.sum);
          chk("cout", cout, e.cout);
          chk("ovf", ovf, e.ovf);
          if (e.chk_lat) chk("latency", cyc - e.acc_cyc, LAT);
        end
      end
      held   = out_valid && !out_ready;
      h_sum  = sum;
      h_cout = cout;
      h_ovf  = ovf;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  vec_t tbl[11];

  initial begin
    bit saw_stall;
    int sent_before;

    tbl[0]  = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
    tbl[1]  = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1};
    tbl[2]  = '{32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0};
    tbl[3]  = '{32'h0000_0003, 32'h0000_0004, 1'b1, 1'b0, 32'h0000_0008, 1'b0, 1'b0};
    tbl[4]  = '{32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1};
    tbl[5]  = '{32'h0000_0000, 32'h0000_0000, 1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b0};
    tbl[6]  = '{32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1};
    tbl[7]  = '{32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
    tbl[8]  = '{32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 1'b0, 32'hACF1_3568, 1'b0, 1'b0};
    tbl[9]  = '{32'h0000_0005, 32'h0000_0005, 1'b1, 1'b1, 32'h0000_0000, 1'b1, 1'b0};
    tbl[10] = '{32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b1, 32'h8000_0000, 1'b0, 1'b1};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_sum", sum, 0);
    chk("rst_cout_ovf", {cout, ovf}, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", in_ready, 1);
    @(posedge clk); #1;

    // Directed table, streamed back to back
    for (int i = 0; i < 11; i++) begin
      exp_t e;
      e.sum = tbl[i].sum; e.cout = tbl[i].cout; e.ovf = tbl[i].ovf;
      e.acc_cyc = 0; e.chk_lat = 1'b0;
      send(tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].sub, e);
    end
    drain();

    // 8 random beats with a 4-cycle consumer stall mid-stream
    lat_exact = 1'b0;
    saw_stall = 1'b0;
    fork
      begin
        for (int i = 0; i < 8; i++)
          send_model($urandom, $urandom, 1'($urandom_range(1)), 1'b0);
      end
      begin
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (4) begin
          @(negedge clk);
          if (!in_ready) saw_stall = 1'b1;
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    drain();
    chk("stall_in_ready_dropped", saw_stall, 1);
    lat_exact = 1'b1;

    // Reset with two beats in flight
    out_ready = 1'b0;
    send_model(32'h0000_1111, 32'h0000_2222, 1'b0, 1'b0);
    send_model(32'h0000_3333, 32'h0000_4444, 1'b1, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_in_ready", in_ready, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_sum", sum, 0);
    @(posedge clk); #1;
    out_ready = 1'b1;
    sent_before = n_sent;
    n_recv = 0;
    begin
      exp_t e;
      e.sum = 32'd8; e.cout = 1'b0; e.ovf = 1'b0; e.acc_cyc = 0; e.chk_lat = 1'b0;
      send(32'd3, 32'd4, 1'b1, 1'b0, e);
    end
    drain();
    chk("midrst_one_result", n_recv, n_sent - sent_before);

    // Long back-to-back random stream: no bubbles, fixed latency
    wait_cnt = 0;
    for (int i = 0; i < 10000; i++) begin
      logic [W-1:0] ra;
      ra = $urandom;
      if (i % 8 == 0)
        send_model(ra, ~ra, 1'b1, 1'b0);
      else
        send_model(ra, $urandom, 1'($urandom_range(1)), 1'($urandom_range(1)));
    end
    drain();
    chk("stream_no_bubbles", wait_cnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/prefix_adder_pipe.md
# prefix_adder_pipe

Pipelined, parametrised Knowles-family parallel-prefix adder with a valid/ready stream interface. It generalises the single-bit propagate/generate input cell to a WIDTH-bit bitwise PG stage, a log2(WIDTH)-level prefix tree (Kogge-Stone fan-out, 1-Knowles), an add/subtract mode, and signed-overflow detection. It is the registered datapath adder used between the operand and result stages of the arithmetic unit.

## Interface
Parameters:
- WIDTH, 32, operand width; must be a power of two, 2..64.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand beat present.
- in_ready  out  1  block accepts the beat this cycle.
- a  in  WIDTH  first addend.
- b  in  WIDTH  second addend.
- cin  in  1  carry-in, used only when sub=0.
- sub  in  1  1: result = a - b (b inverted, carry-in forced 1, cin ignored).
- out_valid  out  1  result beat present.
- out_ready  in  1  consumer accepts the result.
- sum  out  WIDTH  result, modulo 2^WIDTH.
- cout  out  1  carry out of bit WIDTH-1; for sub=1, 1 means no borrow.
- ovf  out  1  signed overflow, C[WIDTH] xor C[WIDTH-1].

## Operation
- Stage S1 (input PG): bb = b xor {WIDTH{sub}}, c0 = sub ? 1 : cin. Compute p[i] = a[i] xor bb[i] and g[i] = a[i] and bb[i]. Fold the carry-in into bit 0: g[0] = g[0] | (p[0] & c0). Register p, g, and c0 with valid v1.
- Stage S2 (prefix tree and sum): LEVELS = log2(WIDTH) levels. At level k with span d = 2^k, each bit i >= d combines (G,P)[i] with (G,P)[i-d]: G = Gi | (Pi & Gj), P = Pi & Pj. Bits i < d pass through unchanged.
- Carries: C[0] = c0 and C[i] = G[i-1] for i >= 1; cout = G[WIDTH-1].
- Sum: sum[i] = p[i] xor C[i], using the original bitwise p.
- sum, cout, and ovf are registered with valid v2. v2 drives out_valid.
- Handshake: every stage holds its data until it is accepted. ready_last = !v_last | out_ready, ready_k = !v_k | ready_{k+1}, in_ready = ready_S1 & !rst.
- A beat transfers on in_valid & in_ready and leaves on out_valid & out_ready.
- Stalled stages keep their registers unchanged. No beat is ever dropped or duplicated.
- Simultaneous accept and emit in the same cycle is legal, giving a throughput of 1 beat per cycle.
- Output data is stable while out_valid=1 and out_ready=0.

## Timing
- Reset: all valids clear. sum=0, cout=0, ovf=0, out_valid=0, in_ready=0 while rst=1 and in_ready=1 the cycle after.
- Reset mid-operation discards every in-flight beat. The first beat accepted after reset emerges unaffected.
- Latency: 2 cycles from accept to out_valid (3 with PREFIX_ADDER_MID_REG_EN). No bubbles while out_ready=1.
- The in_ready combinational path depends on out_ready through the ready chain. No other combinational input-to-output paths exist.
- The critical path of S2 is LEVELS prefix cells plus the sum XOR.

## Configuration
- PREFIX_ADDER_MID_REG_EN defined: a pipeline register (stage S2a, with its own valid and ready) is inserted after level floor(LEVELS/2) of the prefix tree. It holds partial G/P, p, and c0. Latency becomes 3 and throughput stays 1 per cycle.
- Not defined: the tree is fully combinational inside S2 and latency is 2.
- Results are bit-identical in both builds.

## Structure
- Package prefix_adder_pkg holds:
  - the pg_t struct {g, p};
  - the function clog2-based LEVELS constant;
  - the MID_LEVEL constant, floor(LEVELS/2).
- Sub-module prefix_cell: a combinational black cell (G,P) op (G,P), instantiated by generate loops per level and bit.
- Top-level contents: handshake valids, stage registers, and the macro-guarded mid register.

## Test plan
- WIDTH=32, a=0xFFFFFFFF, b=0x00000001, sub=0, cin=0 -> sum=0x00000000, cout=1, ovf=0, out_valid 2 cycles after accept.
- a=0x7FFFFFFF, b=1, sub=0 -> sum=0x80000000, cout=0, ovf=1. Then a=5, b=7, sub=1 -> sum=0xFFFFFFFE, cout=0, ovf=0.
- Stream 8 random beats with out_ready held 0 for 4 cycles mid-stream -> in_ready drops once the stages fill, outputs hold stable, and all 8 results arrive in order against the reference a+b+cin.
- Assert rst for 1 cycle with 2 beats in flight -> out_valid=0 and sum=0 next cycle; a new beat a=3, b=4, cin=1 yields sum=8 at latency.
- Continuous back-to-back input with out_ready=1, run under both macro settings and WIDTH in {2, 8, 64} -> one result per cycle, latency 2 or 3, and 10k random vectors match the model, including cin=1 with a+b=all-ones.
